// File: rtl/chan_packer.sv
// chan_packer: packs a serial I/Q sample stream into AXI-Stream frames.
// Each set of 2*NUM_CHANS words becomes one frame: a header word followed
// by NUM_CHANS {Q,I} data words. A set is written speculatively through a
// shadow pointer and becomes visible only when its last word arrives, so
// sets that are dropped or cut short by resync never reach the reader.
//
// Output handshake: a word transfers on a rising aclk edge where
// m_axis_tvalid and m_axis_tready are both 1. Once tvalid is raised it
// stays high, and tdata/tlast stay unchanged, until that transfer happens.
module chan_packer #(
  parameter int SAMP_WIDTH = 16,
  parameter int NUM_CHANS  = 13,
  parameter int FIFO_DEPTH = 64
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic [SAMP_WIDTH-1:0]         s_data,
  input  logic                          s_valid,
  input  logic                          resync,
  input  logic [4:0]                    gain_shift,
  output logic [31:0]                   m_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast,
  output logic [15:0]                   drop_count,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int WORDS = 2 * NUM_CHANS;
  localparam int WCW   = $clog2(WORDS);
  localparam logic [WCW-1:0] LAST_W  = WCW'(WORDS - 1);
  // A set needs NUM_CHANS+1 free entries; any level above this leaves too few.
  localparam logic [AW:0]    MAX_LVL = (AW + 1)'(FIFO_DEPTH - NUM_CHANS - 1);

  // Entry layout: {tlast, tdata}.
  logic [32:0]    mem [FIFO_DEPTH];

  logic [WCW-1:0] wcnt;
  logic [WCW-1:0] cur_w;
  logic [7:0]     seq;
  logic           drop_flag;
  logic           hdr_flag;   // header of the set in flight carried drop_flag=1
  logic           dropping;   // set in flight was rejected at word 0
  logic [15:0]    drop_cnt;
  logic [15:0]    i_hold;
  logic [15:0]    samp16;
  logic [AW:0]    wr_commit;
  logic [AW:0]    wr_shadow;
  logic [AW:0]    wr_vis;     // commit pointer as seen by the read side
  logic [AW:0]    rd_ptr;     // entry currently presented (or next to present)
  logic [AW:0]    rd_nxt;
  logic [AW:0]    level;
  logic           acc_w0;
  logic           acc_odd;
  logic           acc_last;
  logic           no_room;
  logic           wr_en;
  logic [AW-1:0]  wr_addr;
  logic [32:0]    wr_word;

  // A resync in the same cycle as a valid word makes that word word 0.
  assign cur_w    = resync ? '0 : wcnt;
  assign acc_w0   = s_valid && (cur_w == '0);
  assign acc_odd  = s_valid && cur_w[0];
  assign acc_last = s_valid && (cur_w == LAST_W);
  assign samp16   = 16'($signed(s_data));

  // Level counts the presented word until it is accepted downstream.
  assign level    = wr_commit - rd_ptr;
  assign no_room  = level > MAX_LVL;

  assign rd_nxt     = rd_ptr + {{AW{1'b0}}, (m_axis_tvalid && m_axis_tready)};
  assign drop_count = drop_cnt;
  assign fifo_level = level;

  // Select the buffer write: header on word 0, packed {Q,I} on odd words.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = wr_shadow[AW-1:0];
    wr_word = '0;
    if (acc_w0 && !no_room) begin
      wr_en   = 1'b1;
      wr_addr = wr_commit[AW-1:0];
      wr_word = {1'b0, 8'hA5, seq, gain_shift, 10'd0, drop_flag};
    end else if (acc_odd && !dropping) begin
      wr_en   = 1'b1;
      wr_addr = wr_shadow[AW-1:0];
      wr_word = {acc_last, samp16, i_hold};
    end
  end

  // Frame buffer storage; no reset so it maps onto plain RAM.
  always_ff @(posedge aclk) begin
    if (wr_en) mem[wr_addr] <= wr_word;
  end

  // Input framing, drop decision, shadow and commit pointers.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wcnt      <= '0;
      seq       <= '0;
      drop_flag <= 1'b0;
      hdr_flag  <= 1'b0;
      dropping  <= 1'b0;
      drop_cnt  <= '0;
      i_hold    <= '0;
      wr_commit <= '0;
      wr_shadow <= '0;
      wr_vis    <= '0;
    end else begin
      if (s_valid) wcnt <= (cur_w == LAST_W) ? '0 : cur_w + 1'b1;
      else if (resync) wcnt <= '0;

      if (resync) wr_shadow <= wr_commit;

      if (s_valid && !cur_w[0]) i_hold <= samp16;

      if (acc_w0) begin
        seq <= seq + 1'b1;
        if (no_room) begin
          dropping  <= 1'b1;
          drop_flag <= 1'b1;
          if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 1'b1;
        end else begin
          dropping  <= 1'b0;
          hdr_flag  <= drop_flag;
          wr_shadow <= wr_commit + 1'b1;
        end
      end

      if (acc_odd && !dropping) begin
        wr_shadow <= wr_shadow + 1'b1;
        if (acc_last) begin
          wr_commit <= wr_shadow + 1'b1;
          if (hdr_flag) drop_flag <= 1'b0;
        end
      end

      wr_vis <= wr_commit;
    end
  end

  // Registered first-word-fall-through head: reload when empty or accepted.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rd_ptr        <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tdata  <= '0;
    end else begin
      rd_ptr <= rd_nxt;
      if (!m_axis_tvalid || m_axis_tready) begin
        m_axis_tvalid                <= (wr_vis != rd_nxt);
        {m_axis_tlast, m_axis_tdata} <= mem[rd_nxt[AW-1:0]];
      end
    end
  end

endmodule
